icache_assoc: RTL and testbench



---
 rtl/icache_pkg.sv | 20 ++
 rtl/plru_tree.sv | 47 ++++
 rtl/icache_assoc.sv | 175 +++++++++++++++++
 tb/tb_icache_assoc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and address-field width helpers for the instruction cache.
package icache_pkg;
   localparam int LINE_W   = 256;
   localparam int WORD_W   = 32;
   localparam int OFFSET_W = 5;
   localparam int WSEL_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   function automatic int tag_w(input int s_index);
      return 32 - OFFSET_W - s_index;
   endfunction

   function automatic int index_w(input int s_index);
      return s_index;
   endfunction
endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set, purely combinational. Level l of the tree decides bit l of the
// way number (the root picks way[0]); a set node bit steers the victim walk toward way bit = 1.
module plru_tree
   import icache_pkg::*;
#(
   parameter  int WAYS = 4,
   localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1
) (
   input  logic [PW-1:0] state,
   input  logic [WW-1:0] access_way,
   output logic [WW-1:0] victim,
   output logic [PW-1:0] next_state
);
   localparam int LVL = $clog2(WAYS);

   always_comb begin : walk
      int            pre;
      logic [PW-1:0] rem;
      pre = 0;
      rem = '0;
      for (int l = 0; l < LVL; l++) begin
         // nodes of level l live at (2**l - 1) + (way bits already chosen)
         rem = state >> ((1 << l) - 1 + pre);
         if (rem[0]) begin
            pre = pre | (1 << l);
         end
      end
      victim = WW'(pre);
   end

   always_comb begin : update
      int            node;
      logic [WW-1:0] rem;
      logic          flip;
      next_state = state;
      node       = 0;
      rem        = '0;
      flip       = 1'b0;
      for (int l = 0; l < LVL; l++) begin
         node       = (1 << l) - 1 + (int'(access_way) & ((1 << l) - 1));
         rem        = access_way >> l;
         flip       = ~rem[0];
         next_state = (next_state & ~(PW'(1) << node)) | (PW'(flip) << node);
      end
   end
endmodule

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache: hits answer in the request cycle, misses fill a
// 256-bit line and hit one cycle after the fill. Build with ICACHE_FLUSH_EN to add a flush input.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int S_INDEX = 3,
   parameter int WAYS    = 4
) (
   input  logic         clk,
   input  logic         rst,
`ifdef ICACHE_FLUSH_EN
   input  logic         flush,
`endif
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  mem_address,
   output logic         mem_resp,
   output logic [31:0]  mem_rdata_cpu,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [255:0] pmem_rdata
);
   localparam int SETS  = 2 ** S_INDEX;
   localparam int TAG_W = tag_w(S_INDEX);
   localparam int IDX_W = index_w(S_INDEX);
   localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

   logic [LINE_W-1:0] data_arr  [SETS][WAYS];
   logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
   logic [WAYS-1:0]   valid_arr [SETS];
   logic [PW-1:0]     plru_arr  [SETS];

   state_t state, state_n;
   logic [31-OFFSET_W:0] line_addr;

   logic [IDX_W-1:0]  req_idx, fill_idx, acc_idx;
   logic [TAG_W-1:0]  req_tag, fill_tag;
   logic [WSEL_W-1:0] word_sel;
   logic [WAYS-1:0]   hit_vec;
   logic              hit;
   logic [WW-1:0]     hit_way, fill_way, acc_way, plru_victim;
   logic [PW-1:0]     plru_cur, plru_next;
   logic [LINE_W-1:0] hit_line;
   logic              latch_addr, do_fill, do_touch, rd_hit;
   logic              unused_bits;
`ifdef ICACHE_FLUSH_EN
   logic              clear_valid, flush_pend;
`endif

   assign req_idx     = mem_address[OFFSET_W +: IDX_W];
   assign req_tag     = mem_address[31 -: TAG_W];
   assign word_sel    = mem_address[OFFSET_W-1 -: WSEL_W];
   assign fill_idx    = line_addr[0 +: IDX_W];
   assign fill_tag    = line_addr[31-OFFSET_W -: TAG_W];
   assign unused_bits = ^mem_address[1:0];

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WW'(w);
      end
   end

   assign hit      = |hit_vec;
   assign hit_line = data_arr[req_idx][hit_way];

   // an empty way always beats the PLRU choice, lowest index first
   always_comb begin
      fill_way = plru_victim;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_arr[fill_idx][w]) fill_way = WW'(w);
      end
   end

   assign acc_idx  = (state == FETCH) ? fill_idx : req_idx;
   assign acc_way  = (state == FETCH) ? fill_way : hit_way;
   assign plru_cur = plru_arr[acc_idx];

   plru_tree #(.WAYS(WAYS)) u_plru (
      .state      (plru_cur),
      .access_way (acc_way),
      .victim     (plru_victim),
      .next_state (plru_next)
   );

   always_comb begin
      state_n    = state;
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      latch_addr = 1'b0;
      do_fill    = 1'b0;
      do_touch   = 1'b0;
      rd_hit     = 1'b0;
`ifdef ICACHE_FLUSH_EN
      clear_valid = 1'b0;
`endif
      unique case (state)
         IDLE: begin
`ifdef ICACHE_FLUSH_EN
            if (flush) begin
               clear_valid = 1'b1;
            end else
`endif
            if (mem_read && hit) begin
               mem_resp = 1'b1;
               rd_hit   = 1'b1;
               do_touch = 1'b1;
            end else if (mem_read) begin
               latch_addr = 1'b1;
               state_n    = FETCH;
            end else if (mem_write) begin
               mem_resp = 1'b1;
            end
         end
         FETCH: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               do_fill  = 1'b1;
               do_touch = 1'b1;
               state_n  = IDLE;
`ifdef ICACHE_FLUSH_EN
               clear_valid = flush | flush_pend;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign mem_rdata_cpu = rd_hit ? hit_line[{word_sel, 5'b00000} +: WORD_W] : '0;
   assign pmem_address  = {line_addr, {OFFSET_W{1'b0}}};
   assign pmem_write    = 1'b0;
   assign pmem_wdata    = '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         for (int s = 0; s < SETS; s++) begin
            valid_arr[s] <= '0;
            plru_arr[s]  <= '0;
         end
`ifdef ICACHE_FLUSH_EN
         flush_pend <= 1'b0;
`endif
      end else begin
         state <= state_n;
         if (do_touch) plru_arr[acc_idx] <= plru_next;
         if (do_fill) valid_arr[fill_idx][fill_way] <= 1'b1;
`ifdef ICACHE_FLUSH_EN
         // a flush seen mid-fill waits for the fill, then wipes the new line as well
         if (clear_valid) begin
            for (int s = 0; s < SETS; s++) valid_arr[s] <= '0;
         end
         if (state == FETCH) flush_pend <= (flush_pend | flush) & ~pmem_resp;
         else                flush_pend <= 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (latch_addr) line_addr <= mem_address[31:OFFSET_W];
      if (do_fill && !rst) begin
         data_arr[fill_idx][fill_way] <= pmem_rdata;
         tag_arr[fill_idx][fill_way]  <= fill_tag;
      end
   end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at S_INDEX=3, WAYS=4; flush steps run when ICACHE_FLUSH_EN is set.
module tb_icache_assoc;
   logic         clk = 1'b0;
   logic         rst, mem_read, mem_write, pmem_resp;
   logic [31:0]  mem_address;
   logic [255:0] pmem_rdata;
   logic         mem_resp, pmem_read, pmem_write;
   logic [31:0]  mem_rdata_cpu, pmem_address;
   logic [255:0] pmem_wdata;
`ifdef ICACHE_FLUSH_EN
   logic         flush;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   icache_assoc #(.S_INDEX(3), .WAYS(4)) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef ICACHE_FLUSH_EN
      .flush         (flush),
`endif
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_resp      (mem_resp),
      .mem_rdata_cpu (mem_rdata_cpu),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_address  (pmem_address),
      .pmem_wdata    (pmem_wdata),
      .pmem_resp     (pmem_resp),
      .pmem_rdata    (pmem_rdata)
   );

   // line model: word i of a line built from base is base + i
   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] base, input logic [31:0] addr);
      return base + {29'b0, addr[4:2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic hit_read(input logic [31:0] addr, input logic [31:0] base, input string tag);
      @(negedge clk);
      mem_read    = 1'b1;
      mem_address = addr;
      #1;
      chk({tag, "_resp"},   32'(mem_resp),  32'd1);
      chk({tag, "_data"},   mem_rdata_cpu,  word_of(base, addr));
      chk({tag, "_nofill"}, 32'(pmem_read), 32'd0);
   endtask

   // pmem_read must stay up for lat+1 cycles; pmem_resp is given in the last of them
   task automatic miss_read(input logic [31:0] addr, input logic [31:0] base, input int lat,
                            input string tag);
      int t0;
      @(negedge clk);
      mem_read    = 1'b1;
      mem_address = addr;
      t0          = cyc;
      #1;
      chk({tag, "_miss"},     32'(mem_resp), 32'd0);
      chk({tag, "_missdata"}, mem_rdata_cpu, 32'd0);
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            mem_read    = 1'b0;
            mem_address = 32'hFFFF_FFE4;
         end
         if (k == lat + 1) begin
            pmem_resp  = 1'b1;
            pmem_rdata = mk_line(base);
         end
         #1;
         chk({tag, "_pread"}, 32'(pmem_read), 32'd1);
         if (k == 1 || k == lat + 1) chk({tag, "_paddr"}, pmem_address, {addr[31:5], 5'b0});
      end
      @(negedge clk);
      pmem_resp   = 1'b0;
      pmem_rdata  = '0;
      mem_read    = 1'b1;
      mem_address = addr;
      #1;
      chk({tag, "_lat"},  32'(cyc - t0),  32'(lat + 2));
      chk({tag, "_resp"}, 32'(mem_resp),  32'd1);
      chk({tag, "_data"}, mem_rdata_cpu,  word_of(base, addr));
   endtask

   initial begin
      rst         = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      pmem_resp   = 1'b0;
      pmem_rdata  = '0;
`ifdef ICACHE_FLUSH_EN
      flush       = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1;
      chk("rst_resp",   32'(mem_resp),     32'd0);
      chk("rst_pread",  32'(pmem_read),    32'd0);
      chk("rst_pwrite", 32'(pmem_write),   32'd0);
      chk("rst_wdata",  32'(|pmem_wdata),  32'd0);
      chk("rst_rdata",  mem_rdata_cpu,     32'd0);
      rst = 1'b0;

      // write is acknowledged without touching memory
      @(negedge clk);
      mem_write   = 1'b1;
      mem_address = 32'h40;
      #1;
      chk("wr_resp",   32'(mem_resp),  32'd1);
      chk("wr_rdata",  mem_rdata_cpu,  32'd0);
      chk("wr_nofill", 32'(pmem_read), 32'd0);
      @(negedge clk);
      mem_write = 1'b0;
      #1;
      chk("wr_idle_pread", 32'(pmem_read), 32'd0);
      chk("wr_idle_resp",  32'(mem_resp),  32'd0);

      // cold miss: word1 of the line is 0xDEADBEEF, response 7 cycles after the request
      miss_read(32'h64, 32'hDEADBEEE, 5, "cold");
      chk("cold_word", mem_rdata_cpu, 32'hDEADBEEF);
      hit_read(32'h68, 32'hDEADBEEE, "hit68");

      // fill all four ways of set 0, then hit the first
      miss_read(32'h000, 32'h1000_0000, 2, "f0");
      miss_read(32'h100, 32'h2000_0000, 2, "f1");
      miss_read(32'h200, 32'h3000_0000, 2, "f2");
      miss_read(32'h300, 32'h4000_0000, 2, "f3");
      hit_read(32'h01C, 32'h1000_0000, "h0");

      // PLRU victim is the way holding 0x100; every other line must still hit
      miss_read(32'h400, 32'h5000_0000, 3, "f4");
      hit_read(32'h204, 32'h3000_0000, "h2");
      hit_read(32'h308, 32'h4000_0000, "h3");
      hit_read(32'h000, 32'h1000_0000, "h0b");
      hit_read(32'h410, 32'h5000_0000, "h4");
      miss_read(32'h100, 32'h6000_0000, 1, "f1b");

      // reset two cycles into a fill; the coinciding pmem_resp must be ignored
      @(negedge clk);
      mem_read    = 1'b1;
      mem_address = 32'h800;
      #1;
      chk("rf_miss", 32'(mem_resp), 32'd0);
      @(negedge clk);
      #1;
      chk("rf_pread1", 32'(pmem_read), 32'd1);
      @(negedge clk);
      rst        = 1'b1;
      pmem_resp  = 1'b1;
      pmem_rdata = mk_line(32'h7000_0000);
      #1;
      chk("rf_pread2", 32'(pmem_read), 32'd1);
      @(negedge clk);
      rst        = 1'b0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      mem_read   = 1'b0;
      #1;
      chk("rf_pread_off", 32'(pmem_read), 32'd0);
      chk("rf_resp_off",  32'(mem_resp),  32'd0);
      miss_read(32'h000, 32'h1100_0000, 2, "post_rst0");
      miss_read(32'h800, 32'h1200_0000, 1, "post_rst800");

`ifdef ICACHE_FLUSH_EN
      // flush in IDLE suppresses the hit and invalidates everything
      @(negedge clk);
      mem_read    = 1'b1;
      mem_address = 32'h000;
      flush       = 1'b1;
      #1;
      chk("fl_idle_resp",  32'(mem_resp), 32'd0);
      chk("fl_idle_rdata", mem_rdata_cpu, 32'd0);
      @(negedge clk);
      flush    = 1'b0;
      mem_read = 1'b0;
      miss_read(32'h000, 32'h1500_0000, 2, "fl_idle_after");

      // flush during a fill: the fill completes, then the new line is gone too
      @(negedge clk);
      mem_read    = 1'b1;
      mem_address = 32'hA0;
      #1;
      chk("fl_fetch_miss", 32'(mem_resp), 32'd0);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("fl_fetch_pread1", 32'(pmem_read), 32'd1);
      @(negedge clk);
      flush      = 1'b0;
      pmem_resp  = 1'b1;
      pmem_rdata = mk_line(32'h1400_0000);
      #1;
      chk("fl_fetch_pread2", 32'(pmem_read), 32'd1);
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      #1;
      chk("fl_fetch_after_resp",  32'(mem_resp),  32'd0);
      chk("fl_fetch_after_pread", 32'(pmem_read), 32'd0);
      @(negedge clk);
      mem_read   = 1'b0;
      pmem_resp  = 1'b1;
      pmem_rdata = mk_line(32'h1400_0000);
      #1;
      chk("fl_refetch_pread", 32'(pmem_read), 32'd1);
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      hit_read(32'hA4, 32'h1400_0000, "fl_refill");
`endif

      @(negedge clk);
      mem_read = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
